// File: rtl/mult_cell_seq_pkg.sv
// Shared definitions for the sequential multiplier that drives an external
// 16x16 partial-product cell: op codes, FSM states, latency limits and the
// arithmetic helpers used to fold partial products into a 32-bit result.
package mult_cell_seq_pkg;

  // Operation select carried on req_op.
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,  // low 32 bits of the product
    OP_MULXUU = 2'b01,  // high 32 bits, both operands unsigned
    OP_MULXSU = 2'b10,  // high 32 bits, A signed, B unsigned
    OP_MULXSS = 2'b11   // high 32 bits, both operands signed
  } op_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_LO = 3'd1,
    ST_WAIT_LO  = 3'd2,
    ST_ISSUE_HI = 3'd3,
    ST_WAIT_HI  = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  // Legal range of the external cell pipeline depth.
  localparam int CELL_LATENCY_MIN = 1;
  localparam int CELL_LATENCY_MAX = 3;

  // Wait counter must reach CELL_LATENCY_MAX (one extra cycle in WAIT_HI).
  localparam int CNT_W = $clog2(CELL_LATENCY_MAX + 1);

  // Fold the three low-half partial products into the exact 49-bit sum
  // p1 + ((p2 + p3) << 16). The middle sum keeps its carry (33 bits).
  function automatic logic [48:0] combine_lo(input logic [31:0] p1,
                                             input logic [31:0] p2,
                                             input logic [31:0] p3);
    logic [32:0] mid;
    mid = {1'b0, p2} + {1'b0, p3};
    return {17'b0, p1} + {mid, 16'b0};
  endfunction

  // Turn the unsigned high word into the signed variants. A negative operand
  // of weight -2^31 contributes -(other operand) * 2^32 to the product, which
  // lands entirely in the high word as a subtraction modulo 2^32.
  function automatic logic [31:0] sign_fix(input op_e         op,
                                           input logic [31:0] high_u,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = high_u;
    case (op)
      OP_MULXSU: begin
        if (a[31]) r = r - b;
      end
      OP_MULXSS: begin
        if (a[31]) r = r - b;
        if (b[31]) r = r - a;
      end
      default: r = high_u;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mult_cell_seq.sv
// Sequential 32x32 multiplier front-end. It time-multiplexes an external
// pipelined 16x16 partial-product cell: one issue for the low three partial
// products and, for the high-word ops, a second issue for the A_hi*B_hi term.
// The cell is owned by the parent; this block only drives and reads it.
module mult_cell_seq
  import mult_cell_seq_pkg::*;
#(
  parameter int CELL_LATENCY = 1  // legal range CELL_LATENCY_MIN..CELL_LATENCY_MAX
) (
  input  logic        clk,
  input  logic        reset_n,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_op,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  // partial-product cell
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  // Counter values at which the cell output is valid (LO_LAST) and, in
  // WAIT_HI, the extra combine cycle after hh has been registered (HI_LAST).
  localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(CELL_LATENCY - 1);
  localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(CELL_LATENCY);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [16:0]      sum_hi_q, sum_hi_d;   // sum49[48:32], carried into the high word
  logic [31:0]      hh_q, hh_d;           // A_hi * B_hi from the second issue
  logic [31:0]      rsp_data_q, rsp_data_d;

  logic [48:0]      sum49;
  logic [31:0]      high_u;
  logic [31:0]      high_final;
  logic             accept;
  logic             rsp_done;

  assign accept   = req_valid && req_ready;
  assign rsp_done = rsp_valid && rsp_ready;

  // Exact low-half sum straight off the cell outputs; sampled in WAIT_LO.
  assign sum49 = combine_lo(cell_p1, cell_p2, cell_p3);

  // High word from registered terms only, so the correction subtractors do
  // not sit behind the cell's output path.
  assign high_u     = hh_q + {15'b0, sum_hi_q};
  assign high_final = sign_fix(op_q, high_u, a_q, b_q);

  // Handshake and cell drive decode from the current state.
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign cell_en   = (state_q == ST_ISSUE_LO) || (state_q == ST_ISSUE_HI);

  // Cell operands are zero whenever the cell is not being issued.
  always_comb begin
    cell_src1 = 32'h0;
    cell_src2 = 32'h0;
    case (state_q)
      ST_ISSUE_LO: begin
        cell_src1 = a_q;
        cell_src2 = b_q;
      end
      ST_ISSUE_HI: begin
        cell_src1 = {16'h0, a_q[31:16]};
        cell_src2 = {16'h0, b_q[31:16]};
      end
      default: begin
        cell_src1 = 32'h0;
        cell_src2 = 32'h0;
      end
    endcase
  end

  // Sequencer next-state and datapath capture.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    sum_hi_d   = sum_hi_q;
    hh_d       = hh_q;
    rsp_data_d = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Operands are frozen here; later req_* activity is ignored.
          a_d     = req_a;
          b_d     = req_b;
          op_d    = op_e'(req_op);
          cnt_d   = '0;
          state_d = ST_ISSUE_LO;
        end
      end

      ST_ISSUE_LO: begin
        cnt_d   = '0;
        state_d = ST_WAIT_LO;
      end

      ST_WAIT_LO: begin
        if (cnt_q == LO_LAST) begin
          cnt_d    = '0;
          sum_hi_d = sum49[48:32];
          if (op_q == OP_MUL) begin
            rsp_data_d = sum49[31:0];
            state_d    = ST_RESP;
          end else begin
            state_d = ST_ISSUE_HI;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_ISSUE_HI: begin
        cnt_d   = '0;
        state_d = ST_WAIT_HI;
      end

      ST_WAIT_HI: begin
        if (cnt_q == LO_LAST) begin
          hh_d  = cell_p1;
          cnt_d = cnt_q + 1'b1;
        end else if (cnt_q == HI_LAST) begin
          cnt_d      = '0;
          rsp_data_d = high_final;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        // Return to IDLE only; req_ready is low this cycle so a pending
        // request waits for the next one.
        if (rsp_done) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MUL;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      cnt_q      <= '0;
      sum_hi_q   <= 17'h0;
      hh_q       <= 32'h0;
      rsp_data_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      sum_hi_q   <= sum_hi_d;
      hh_q       <= hh_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_mult_cell_seq.sv
// Self-checking bench for mult_cell_seq. Provides a pipelined 16x16 cell
// model, directed vectors, a stalled back-to-back case, a mid-operation
// reset and a randomized run compared against a 64-bit product model.
module tb_mult_cell_seq;
  import mult_cell_seq_pkg::*;

  localparam int L = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [1:0]  req_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] cell_src1, cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1, cell_p2, cell_p3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_cell_seq #(.CELL_LATENCY(L)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .cell_src1 (cell_src1),
    .cell_src2 (cell_src2),
    .cell_en   (cell_en),
    .cell_p1   (cell_p1),
    .cell_p2   (cell_p2),
    .cell_p3   (cell_p3)
  );

  // Partial-product cell model: L-deep pipeline, zero when not enabled.
  logic [31:0] p1_pipe [L];
  logic [31:0] p2_pipe [L];
  logic [31:0] p3_pipe [L];

  function automatic logic [31:0] pp(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  initial begin
    for (int i = 0; i < L; i++) begin
      p1_pipe[i] = 32'h0;
      p2_pipe[i] = 32'h0;
      p3_pipe[i] = 32'h0;
    end
  end

  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) begin
      p1_pipe[i] <= p1_pipe[i-1];
      p2_pipe[i] <= p2_pipe[i-1];
      p3_pipe[i] <= p3_pipe[i-1];
    end
    p1_pipe[0] <= cell_en ? pp(cell_src1[15:0],  cell_src2[15:0])  : 32'h0;
    p2_pipe[0] <= cell_en ? pp(cell_src1[15:0],  cell_src2[31:16]) : 32'h0;
    p3_pipe[0] <= cell_en ? pp(cell_src1[31:16], cell_src2[15:0])  : 32'h0;
  end

  assign cell_p1 = p1_pipe[L-1];
  assign cell_p2 = p2_pipe[L-1];
  assign cell_p3 = p3_pipe[L-1];

  // Reference: full 64-bit product of the (sign- or zero-) extended operands.
  function automatic logic [31:0] ref_result(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [1:0]  op);
    logic [63:0] xa, xb, prod;
    xa = (op == OP_MULXSU || op == OP_MULXSS) ? {{32{a[31]}}, a} : {32'h0, a};
    xb = (op == OP_MULXSS) ? {{32{b[31]}}, b} : {32'h0, b};
    prod = xa * xb;
    return (op == OP_MUL) ? prod[31:0] : prod[63:32];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk);
  endtask

  // Scrambles req_* while the op is in flight; returns at the rsp_valid negedge.
  task automatic wait_rsp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [31:0] exp, input string tag);
    int cyc       = 0;
    int pulses    = 0;
    bit src_bad   = 1'b0;
    bit src_wrong = 1'b0;
    int exp_lat   = (op == OP_MUL) ? 2 + L : 4 + 2 * L;
    do begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      req_a     = $urandom;
      req_b     = $urandom;
      req_op    = 2'($urandom);
      if (cell_en) begin
        pulses++;
        if (pulses == 1) begin
          if (cell_src1 !== a || cell_src2 !== b) src_wrong = 1'b1;
        end else begin
          if (cell_src1 !== {16'h0, a[31:16]} || cell_src2 !== {16'h0, b[31:16]}) src_wrong = 1'b1;
        end
      end else if (cell_src1 !== 32'h0 || cell_src2 !== 32'h0) begin
        src_bad = 1'b1;
      end
    end while (rsp_valid !== 1'b1 && cyc < 64);
    check($sformatf("%s_rsp_valid", tag), rsp_valid, 1);
    check($sformatf("%s_latency", tag), cyc, exp_lat);
    check($sformatf("%s_data", tag), rsp_data, exp);
    check($sformatf("%s_cell_en_pulses", tag), pulses, (op == OP_MUL) ? 1 : 2);
    check($sformatf("%s_cell_src", tag), src_wrong, 0);
    check($sformatf("%s_src_zero_idle", tag), src_bad, 0);
  endtask

  // Stall the response for 'hold' cycles, optionally with a new request
  // pending, then handshake. Returns at a negedge with the DUT back in IDLE.
  task automatic drain(input int hold, input bit next_valid,
                       input logic [31:0] na, input logic [31:0] nb, input logic [1:0] nop);
    logic [31:0] held = rsp_data;
    bit bad = 1'b0;
    rsp_ready = 1'b0;
    req_valid = next_valid;
    req_a     = na;
    req_b     = nb;
    req_op    = nop;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== held || req_ready !== 1'b0) bad = 1'b1;
    end
    if (hold > 0) check("stall_hold", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_released", rsp_valid, 0);
    check("idle_after_rsp", req_ready, 1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom & 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t dir_vecs [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    bit          stray;

    dir_vecs = '{
      '{32'h0001_0002, 32'h0003_0004, OP_MUL,    32'h000A_0008},
      '{32'h0001_0002, 32'h0003_0004, OP_MULXUU, 32'h0000_0003},
      '{32'hFFFF_FFFF, 32'h0000_0002, OP_MULXUU, 32'h0000_0001},
      '{32'hFFFF_FFFF, 32'h0000_0002, OP_MULXSU, 32'hFFFF_FFFF},
      '{32'hFFFF_FFFF, 32'h0000_0002, OP_MULXSS, 32'hFFFF_FFFF},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL,    32'h0000_0001},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULXUU, 32'hFFFF_FFFE},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULXSS, 32'h0000_0000},
      '{32'h8000_0000, 32'h8000_0000, OP_MULXSS, 32'h4000_0000},
      '{32'h8000_0000, 32'h8000_0000, OP_MULXSU, 32'hC000_0000}
    };

    reset_n   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a     = 32'h0;
    req_b     = 32'h0;
    req_op    = 2'b00;

    // Reset state.
    #12;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_cell_en", cell_en, 0);
    check("rst_cell_src1", cell_src1, 0);
    check("rst_cell_src2", cell_src2, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);

    // Directed vectors.
    foreach (dir_vecs[i]) begin
      issue(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].op);
      wait_rsp(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].op, dir_vecs[i].exp, $sformatf("dir%0d", i));
      drain(0, 1'b0, 32'h0, 32'h0, 2'b00);
    end

    // Stalled response with a new request pending; it is taken only after
    // the handshake, and the held-back operands are the ones computed.
    issue(32'h1234_5678, 32'h0000_0010, OP_MUL);
    wait_rsp(32'h1234_5678, 32'h0000_0010, OP_MUL, 32'h2345_6780, "stall_first");
    drain(4, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, OP_MULXUU);
    issue(32'hDEAD_BEEF, 32'hCAFE_F00D, OP_MULXUU);
    wait_rsp(32'hDEAD_BEEF, 32'hCAFE_F00D, OP_MULXUU,
             ref_result(32'hDEAD_BEEF, 32'hCAFE_F00D, OP_MULXUU), "stall_second");
    drain(0, 1'b0, 32'h0, 32'h0, 2'b00);

    // Reset during WAIT_HI discards the operation.
    issue(32'h9ABC_DEF0, 32'h8765_4321, OP_MULXSS);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2 + L) @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_data", rsp_data, 0);
    check("midrst_cell_en", cell_en, 0);
    check("midrst_cell_src1", cell_src1, 0);
    check("midrst_cell_src2", cell_src2, 0);
    @(negedge clk);
    reset_n = 1'b1;
    stray = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stray = 1'b1;
    end
    check("midrst_no_rsp", stray, 0);
    issue(32'h0000_0007, 32'h0000_0006, OP_MUL);
    wait_rsp(32'h0000_0007, 32'h0000_0006, OP_MUL, 32'h0000_002A, "after_rst");
    drain(1, 1'b0, 32'h0, 32'h0, 2'b00);

    // Randomized run against the reference model.
    for (int n = 0; n < 300; n++) begin
      ra  = pick_operand();
      rb  = pick_operand();
      rop = 2'($urandom_range(0, 3));
      issue(ra, rb, rop);
      wait_rsp(ra, rb, rop, ref_result(ra, rb, rop), $sformatf("rnd%0d", n));
      drain($urandom_range(0, 3), 1'b0, 32'h0, 32'h0, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
